// File: rtl/ring_pkg.sv
// ============================================================================
// ring_pkg : flit field layout and stop-controller FSM encodings. Rev 1.0
// ============================================================================
`default_nettype none

package ring_pkg;

  localparam int DST_W       = 4;
  localparam int FLIT_W      = 8;
  localparam int FLIT_V      = FLIT_W - 1;
  localparam int FLIT_DST_HI = FLIT_W - 2;
  localparam int FLIT_DST_LO = FLIT_W - 1 - DST_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STARVE = 2'd2
  } stop_state_e;

endpackage

`default_nettype wire

// File: rtl/ring_inj_fifo.sv
// ============================================================================
// ring_inj_fifo : local injection queue, power-of-two depth, async active-low reset. Rev 1.0
// ============================================================================
`default_nettype none

module ring_inj_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int c_AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr;
  logic [c_AW-1:0]  r_rd;
  logic [c_AW:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign full      = (r_count == c_FULL);
  assign empty     = (r_count == '0);
  assign dout      = r_mem[r_rd];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible through a valid count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/ring_stop_ctrl.sv
// ============================================================================
// ring_stop_ctrl : ring stop inject/eject scheduler with starvation slot request.
// Optional RING_STOP_STATS_EN adds stat_inj/stat_ej/stat_fwd counters. Rev 1.0
// ============================================================================
`default_nettype none

module ring_stop_ctrl
  import ring_pkg::*;
#(
  parameter int DATAWID    = 8,
  parameter int NODE_ID    = 0,
  parameter int NODES      = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inj_valid,
  output logic               inj_ready,
  input  logic [DATAWID-1:0] inj_data,
  input  logic [DATAWID-1:0] ring_in,
  output logic [DATAWID-1:0] ring_out,
  output logic               eject_valid,
  output logic [DATAWID-1:0] eject_data,
  output logic               slot_req,
  input  logic               slot_grant
`ifdef RING_STOP_STATS_EN
  ,
  output logic [31:0]        stat_inj,
  output logic [31:0]        stat_ej,
  output logic [31:0]        stat_fwd
`endif
);

  localparam int c_V      = DATAWID - FLIT_W + FLIT_V;
  localparam int c_DST_HI = DATAWID - FLIT_W + FLIT_DST_HI;
  localparam int c_DST_LO = DATAWID - FLIT_W + FLIT_DST_LO;
  localparam int c_CW     = (STARVE_LIM > 2) ? $clog2(STARVE_LIM) : 1;
  localparam logic [DST_W-1:0]   c_NODE   = DST_W'(NODE_ID);
  localparam logic [DST_W:0]     c_NODES  = (DST_W + 1)'(NODES);
  localparam logic [c_CW-1:0]    c_LIM_M1 = c_CW'(STARVE_LIM - 1);
  localparam logic [DATAWID-1:0] c_VBIT   = {1'b1, {(DATAWID-1){1'b0}}};

  logic               w_in_valid;
  logic [DST_W-1:0]   w_dst;
  logic               w_eject;
  logic               w_fwd;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_blocked;
  logic [DATAWID-1:0] w_head;

  stop_state_e     r_state;
  stop_state_e     r_state_nxt;
  logic [c_CW-1:0] r_cnt;
  logic [c_CW-1:0] r_cnt_nxt;

  assign w_in_valid = ring_in[c_V];
  assign w_dst      = ring_in[c_DST_HI:c_DST_LO];
  assign w_eject    = w_in_valid && ({1'b0, w_dst} < c_NODES) && (w_dst == c_NODE);
  assign w_fwd      = w_in_valid && !w_eject;
  assign w_pop      = !w_fwd && !w_empty && !slot_grant;
  assign w_blocked  = !w_empty && !w_pop;
  assign inj_ready  = !w_full;
  assign w_push     = inj_valid && inj_ready;

  ring_inj_fifo #(
    .WIDTH (DATAWID),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (inj_data),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ring_out    <= '0;
      eject_valid <= 1'b0;
      eject_data  <= '0;
      slot_req    <= 1'b0;
    end else begin
      ring_out    <= w_fwd ? ring_in : (w_pop ? (w_head | c_VBIT) : '0);
      eject_valid <= w_eject;
      if (w_eject) eject_data <= ring_in;
      slot_req    <= (r_state_nxt == STARVE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= r_state_nxt;
      r_cnt   <= r_cnt_nxt;
    end
  end

  // r_cnt holds the number of blocked cycles seen so far while in WAIT.
  always_comb begin
    r_state_nxt = r_state;
    r_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_blocked) begin
          r_state_nxt = WAIT;
          r_cnt_nxt   = c_CW'(1);
        end
      end
      WAIT: begin
        if (!w_blocked) begin
          r_state_nxt = IDLE;
          r_cnt_nxt   = '0;
        end else if (r_cnt == c_LIM_M1) begin
          r_state_nxt = STARVE;
        end else begin
          r_cnt_nxt = r_cnt + c_CW'(1);
        end
      end
      STARVE: begin
        if (!w_blocked) begin
          r_state_nxt = IDLE;
          r_cnt_nxt   = '0;
        end
      end
      default: begin
        r_state_nxt = IDLE;
        r_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef RING_STOP_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_inj <= '0;
      stat_ej  <= '0;
      stat_fwd <= '0;
    end else begin
      if (w_pop)   stat_inj <= stat_inj + 32'd1;
      if (w_eject) stat_ej  <= stat_ej + 32'd1;
      if (w_fwd)   stat_fwd <= stat_fwd + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ring_stop_ctrl.sv
// ============================================================================
// tb_ring_stop_ctrl : directed and randomized bench for ring_stop_ctrl (NODE_ID=3). Rev 1.0
// ============================================================================
`default_nettype none

module tb_ring_stop_ctrl;

  localparam int NID   = 3;
  localparam int DEPTH = 4;
  localparam int LIM   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inj_valid = 1'b0;
  logic [7:0] inj_data = 8'h00;
  logic [7:0] ring_in = 8'h00;
  logic       slot_grant = 1'b0;
  logic       inj_ready;
  logic [7:0] ring_out;
  logic       eject_valid;
  logic [7:0] eject_data;
  logic       slot_req;
`ifdef RING_STOP_STATS_EN
  logic [31:0] stat_inj;
  logic [31:0] stat_ej;
  logic [31:0] stat_fwd;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ring_stop_ctrl #(
    .DATAWID    (8),
    .NODE_ID    (NID),
    .NODES      (12),
    .FIFO_DEPTH (DEPTH),
    .STARVE_LIM (LIM)
  ) dut (
    .clk         (clk),
    .rst         (rst_n),
    .inj_valid   (inj_valid),
    .inj_ready   (inj_ready),
    .inj_data    (inj_data),
    .ring_in     (ring_in),
    .ring_out    (ring_out),
    .eject_valid (eject_valid),
    .eject_data  (eject_data),
    .slot_req    (slot_req),
    .slot_grant  (slot_grant)
`ifdef RING_STOP_STATS_EN
    ,
    .stat_inj    (stat_inj),
    .stat_ej     (stat_ej),
    .stat_fwd    (stat_fwd)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue is a plain SV queue, starvation is a streak of
  // cycles in which a queued flit existed but was not sent.
  logic [7:0] mq[$];
  int         streak;
  int         m_pre;
  bit         m_valid, m_ej, m_fwd, m_pop;
  logic [3:0] m_dst;
  logic [7:0] m_out, m_ed;
  bit         m_ev, m_req;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      streak = 0;
      m_out  = 8'h00;
      m_ev   = 1'b0;
      m_ed   = 8'h00;
      m_req  = 1'b0;
    end else begin
      m_pre   = mq.size();
      m_valid = ring_in[7];
      m_dst   = ring_in[6:3];
      m_ej    = m_valid && (m_dst == 4'(NID));
      m_fwd   = m_valid && !m_ej;
      m_pop   = !m_fwd && (m_pre > 0) && !slot_grant;
      m_ev    = m_ej;
      if (m_ej) m_ed = ring_in;
      if (m_fwd) m_out = ring_in;
      else if (m_pop) begin
        m_out = mq[0] | 8'h80;
        void'(mq.pop_front());
      end else m_out = 8'h00;
      if (inj_valid && (m_pre < DEPTH)) mq.push_back(inj_data);
      streak = ((m_pre > 0) && !m_pop) ? streak + 1 : 0;
      m_req  = (streak >= LIM);
    end
  end

  always @(negedge clk) begin
    check("ring_out", 32'(ring_out), 32'(m_out));
    check("eject_valid", 32'(eject_valid), 32'(m_ev));
    if (m_ev) check("eject_data", 32'(eject_data), 32'(m_ed));
    check("slot_req", 32'(slot_req), 32'(m_req));
    check("inj_ready", 32'(inj_ready), 32'(mq.size() < DEPTH));
  end

  task automatic drive(input logic iv, input logic [7:0] id, input logic [7:0] rin, input logic g);
    inj_valid  = iv;
    inj_data   = id;
    ring_in    = rin;
    slot_grant = g;
    @(negedge clk);
    #1;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_ring_out", 32'(ring_out), 32'h0);
    check("rst_eject_valid", 32'(eject_valid), 32'h0);
    check("rst_slot_req", 32'(slot_req), 32'h0);
    check("rst_inj_ready", 32'(inj_ready), 32'h1);
    rst_n = 1'b1;

    drive(1'b0, 8'h00, 8'h9D, 1'b0);
    check("eject_valid", 32'(eject_valid), 32'h1);
    check("eject_data", 32'(eject_data), 32'h9D);
    check("eject_ring_out", 32'(ring_out), 32'h0);

    drive(1'b0, 8'h00, 8'hF3, 1'b0);
    check("illegal_fwd", 32'(ring_out), 32'hF3);
    check("illegal_no_eject", 32'(eject_valid), 32'h0);

    drive(1'b1, 8'h0A, 8'hA9, 1'b0);
    check("fwd0", 32'(ring_out), 32'hA9);
    drive(1'b0, 8'h00, 8'hAA, 1'b0);
    check("fwd1", 32'(ring_out), 32'hAA);
    drive(1'b0, 8'h00, 8'hAB, 1'b0);
    check("fwd2", 32'(ring_out), 32'hAB);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    check("inj_after_fwd", 32'(ring_out), 32'h8A);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    check("idle_after_inj", 32'(ring_out), 32'h0);

    drive(1'b1, 8'h15, 8'hA9, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b1);
    check("grant_empty_slot", 32'(ring_out), 32'h0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    check("grant_release_inj", 32'(ring_out), 32'h95);

    for (int i = 0; i < 4; i++) drive(1'b1, 8'h20 + 8'(i), 8'hA9, 1'b0);
    check("full_ready", 32'(inj_ready), 32'h0);
    drive(1'b1, 8'h55, 8'hA9, 1'b0);
    check("full_still", 32'(inj_ready), 32'h0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    check("full_pop_out", 32'(ring_out), 32'hA0);
    check("full_pop_ready", 32'(inj_ready), 32'h1);
    for (int i = 1; i < 4; i++) begin
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      check("full_drain", 32'(ring_out), 32'hA0 + 32'(i));
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    check("full_5th_dropped", 32'(ring_out), 32'h0);

    drive(1'b1, 8'h33, 8'hA9, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 8'h00, 8'hA9, 1'b0);
      if (k == 7) check("starve_k7", 32'(slot_req), 32'h0);
      if (k == 8) check("starve_k8", 32'(slot_req), 32'h1);
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    check("starve_inj", 32'(ring_out), 32'hB3);
    check("starve_clear", 32'(slot_req), 32'h0);

    for (int i = 0; i < 3; i++) drive(1'b1, 8'h41 + 8'(i), 8'hA9, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ring_out", 32'(ring_out), 32'h0);
    check("arst_eject_valid", 32'(eject_valid), 32'h0);
    check("arst_eject_data", 32'(eject_data), 32'h0);
    check("arst_slot_req", 32'(slot_req), 32'h0);
    check("arst_inj_ready", 32'(inj_ready), 32'h1);
    inj_valid = 1'b0;
    ring_in   = 8'h00;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    check("arst_queue_gone0", 32'(ring_out), 32'h0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    check("arst_queue_gone1", 32'(ring_out), 32'h0);

    for (int i = 0; i < 3000; i++) begin
      logic [7:0] rin;
      logic [3:0] dst;
      logic       v;
      v   = ((i / 200) % 2 == 1) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 1) == 1);
      dst = ($urandom_range(0, 3) == 0) ? 4'(NID) : 4'($urandom_range(0, 15));
      rin = {v, dst, 3'($urandom_range(0, 7))};
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), rin, ($urandom_range(0, 3) == 0));
    end

    for (int i = 0; i < 8; i++) drive(1'b0, 8'h00, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
